// File: rtl/wrport_pkg.sv
// Shared write-port definitions. The downstream memory block uses the same
// defaults and request record.
package wrport_pkg;

  localparam int WR_AW = 4;
  localparam int WR_DW = 4;

  typedef struct packed {
    logic [WR_AW-1:0] addr;
    logic [WR_DW-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

  // Drain amount for one edge: min(count, 2), or nothing while held.
  function automatic pop_e pop_amount(input logic hold, input int cnt);
    if (hold || cnt == 0) return POP_NONE;
    if (cnt == 1)         return POP_ONE;
    return POP_TWO;
  endfunction

endpackage

// File: rtl/wr_issue_queue_if.sv
// Request handshake plus the two registered memory write ports of the issue queue.
// in_valid/in_ready: a request transfers on a rising edge where both are high;
// in_ready depends only on registered state, and in_valid while in_ready is low is ignored.
interface wr_issue_queue_if import wrport_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW    = WR_AW,
  parameter int DW    = WR_DW
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          hold;

  logic          we1;
  logic          we2;
  logic [AW-1:0] wa1;
  logic [AW-1:0] wa2;
  logic [DW-1:0] wd1;
  logic [DW-1:0] wd2;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_addr, in_data, hold,
    input  in_ready, we1, we2, wa1, wa2, wd1, wd2, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, hold,
    output in_ready, we1, we2, wa1, wa2, wd1, wd2, count
  );

endinterface

// File: rtl/wrq_ring.sv
// Circular entry store with one push port and two read taps at rd_ptr and rd_ptr+1.
// The caller guarantees push only when not full and pop never exceeds count.
module wrq_ring import wrport_pkg::*; #(
  parameter int  DEPTH = 8,
  parameter type T     = req_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  T                       i_data,
  input  pop_e                   i_pop,
  output T                       o_tap0,
  output T                       o_tap1,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_rd_ptr_p1;

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap.
  assign w_rd_ptr_p1 = r_rd_ptr + PW'(1);
  assign o_tap0      = r_mem[r_rd_ptr];
  assign o_tap1      = r_mem[w_rd_ptr_p1];
  assign o_count     = r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop);
      r_count  <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/wr_issue_queue.sv
// FIFO of write requests draining up to two per cycle onto two registered
// memory write ports; port 1 carries the older entry, port 2 the newer.
module wr_issue_queue import wrport_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW    = WR_AW,
  parameter int DW    = WR_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  wr_issue_queue_if.slave    bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic [CW-1:0] w_count;
  logic          w_push;
  pop_e          w_pop;
  entry_t        w_in;
  entry_t        w_tap0;
  entry_t        w_tap1;

  logic          r_we1;
  logic          r_we2;
  logic [AW-1:0] r_wa1;
  logic [AW-1:0] r_wa2;
  logic [DW-1:0] r_wd1;
  logic [DW-1:0] r_wd2;

  // Pop is sized from the pre-edge count, so an entry never drains in its push cycle.
  assign bus.in_ready = (w_count != CW'(DEPTH));
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = pop_amount(bus.hold, int'(w_count));
  assign w_in         = '{addr: bus.in_addr, data: bus.in_data};

  wrq_ring #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_tap0  (w_tap0),
    .o_tap1  (w_tap1),
    .o_count (w_count)
  );

  // Equal addresses in one pair issue unchanged; downstream port-2-wins keeps order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we1 <= 1'b0;
      r_we2 <= 1'b0;
      r_wa1 <= '0;
      r_wa2 <= '0;
      r_wd1 <= '0;
      r_wd2 <= '0;
    end else begin
      r_we1 <= (w_pop != POP_NONE);
      r_we2 <= (w_pop == POP_TWO);
      if (w_pop != POP_NONE) begin
        r_wa1 <= w_tap0.addr;
        r_wd1 <= w_tap0.data;
      end
      if (w_pop == POP_TWO) begin
        r_wa2 <= w_tap1.addr;
        r_wd2 <= w_tap1.data;
      end
    end
  end

  assign bus.we1   = r_we1;
  assign bus.we2   = r_we2;
  assign bus.wa1   = r_wa1;
  assign bus.wa2   = r_wa2;
  assign bus.wd1   = r_wd1;
  assign bus.wd2   = r_wd2;
  assign bus.count = w_count;

endmodule

// File: doc/wr_issue_queue.md
WR_ISSUE_QUEUE -- requirements
Module: wr_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, minimum 4.
REQ-002 Parameter AW, default 4, write-address width.
REQ-003 Parameter DW, default 4, write-data width.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 Port in_valid  input  1  write request present.
REQ-007 Port in_ready  output  1  queue can accept a request this cycle.
REQ-008 Port in_addr  input  AW  request address.
REQ-009 Port in_data  input  DW  request data.
REQ-010 Port hold  input  1  when high, no entries drain this cycle.
REQ-011 Ports we1 / we2  output  1  write enables for memory write ports 1 and 2, registered.
REQ-012 Ports wa1 / wa2  output  AW  write addresses for ports 1 and 2, registered.
REQ-013 Ports wd1 / wd2  output  DW  write data for ports 1 and 2, registered.
REQ-014 Port count  output  clog2(DEPTH)+1  entries currently held.

Function
REQ-015 Queue SHALL be strict FIFO; entries leave in acceptance order.
REQ-016 Push SHALL occur on a rising edge with in_valid and in_ready both high.
REQ-017 in_ready SHALL equal (count != DEPTH), computed from registered count only; no same-cycle bypass when full.
REQ-018 When hold is low, each edge SHALL pop min(count, 2) entries, count taken before that edge's push.
REQ-019 Oldest popped entry SHALL drive port 1 (we1, wa1, wd1); second-oldest SHALL drive port 2 (we2, wa2, wd2).
REQ-020 Two popped entries with equal address SHALL both issue unchanged; port 2 carries the newer one, so the downstream memory's port-2-wins rule keeps program order.
REQ-021 A one-entry pop SHALL assert we1 only; we2 low.
REQ-022 When hold is high or count is 0, we1 and we2 SHALL be low on the following cycle; wa/wd hold their last values.
REQ-023 Latency: an entry pushed at edge N SHALL reach the port outputs no earlier than edge N+1 (entry never drains in its push cycle).
REQ-024 Simultaneous push and pop: count_next = count + push - pop; range 0..DEPTH.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; a two-entry pop SHALL cross the wrap point correctly.
REQ-026 in_valid while in_ready is low SHALL be ignored without state change; no overflow or underflow is possible.

Reset
REQ-027 rst_n low SHALL immediately clear pointers and count and drive we1, we2 low, asynchronously.
REQ-028 wa1, wa2, wd1, wd2 SHALL reset to 0; entry storage is not reset.
REQ-029 in_ready SHALL read 1 during and after reset.
REQ-030 Reset mid-drain SHALL discard all queued entries; no write issues after rst_n rises until a new push.

Structure
REQ-031 AW, DW defaults and the request record type (addr, data) SHALL live in shared package wrport_pkg, common with the downstream memory block.
REQ-032 Storage and pointers SHALL be sub-module wrq_ring (one push port, two read taps at rd_ptr and rd_ptr+1, pop amount 0/1/2); issue registers stay in wr_issue_queue.

Verification
REQ-033 Reset, push (3,A),(5,B) on consecutive cycles, hold=0 -> edge after first push: we1=1 wa1=3 wd1=A; next edge: we1=1 wa1=5 wd1=B, we2=0.
REQ-034 hold=1, push 8 entries (addr 0..7, data = addr) -> in_ready=0 and count=8 after edge 8; release hold -> four consecutive cycles issuing pairs (0,1),(2,3),(4,5),(6,7) on ports (1,2).
REQ-035 Push (9,1) then (9,2) while held, release -> single cycle with we1=we2=1, wa1=wa2=9, wd1=1, wd2=2; downstream memory[9] ends as 2.
REQ-036 Full queue, push attempt with in_valid=1 under hold=1 -> request ignored, count stays 8; hold dropped the same cycle -> count 6 next edge, push accepted only on the following edge.
REQ-037 Continuous push stream with hold=0 for 20 cycles -> pointers wrap at least twice; issued sequence matches pushed sequence exactly (scoreboard).
REQ-038 Assert rst_n low with 5 entries queued and we1=1 -> we1/we2 drop immediately, count=0; no writes after release until new pushes.
